// File: rtl/key_loader_rll16.sv
// Serial key loader: shifts a 16-bit key LSB first into a shadow register,
// optionally checks a trailing even-parity bit, and transfers it to key_out on commit.
module key_loader_rll16 #(
   parameter int KEY_W  = 16,
   parameter bit PAR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             ser_valid,
   input  logic             ser_in,
   input  logic             commit,
   output logic [KEY_W-1:0] key_out,
   output logic             key_ready,
   output logic             busy,
   output logic             err,
   output logic [4:0]       bit_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_PARITY,
      S_ARMED,
      S_ERROR
   } state_t;

   state_t           r_state;
   logic [KEY_W-1:0] r_shadow;
   logic [KEY_W-1:0] r_key;
   logic             r_ready;
   logic             r_busy;
   logic             r_err;
   logic [4:0]       r_cnt;

   state_t           w_state_nxt;
   logic [KEY_W-1:0] w_shadow_nxt;
   logic [KEY_W-1:0] w_key_nxt;
   logic             w_ready_nxt;
   logic             w_err_nxt;
   logic [4:0]       w_cnt_nxt;
   logic             w_busy_nxt;

   // load_start takes priority over every state action, including a commit in ARMED
   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_key_nxt    = r_key;
      w_ready_nxt  = r_ready;
      w_err_nxt    = r_err;
      w_cnt_nxt    = r_cnt;
      if (load_start) begin
         w_state_nxt  = S_SHIFT;
         w_shadow_nxt = '0;
         w_err_nxt    = 1'b0;
         w_cnt_nxt    = '0;
      end else begin
         case (r_state)
            S_SHIFT: begin
               if (ser_valid) begin
                  w_shadow_nxt[r_cnt[3:0]] = ser_in;
                  w_cnt_nxt                = r_cnt + 5'd1;
                  if (r_cnt == 5'd15)
                     w_state_nxt = PAR_EN ? S_PARITY : S_ARMED;
               end
            end
            S_PARITY: begin
               if (ser_valid) begin
                  if ((^r_shadow) ^ ser_in) begin
                     w_state_nxt = S_ERROR;
                     w_err_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (commit) begin
                  w_key_nxt   = r_shadow;
                  w_ready_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: ;
         endcase
      end
      w_busy_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_PARITY) ||
                   (w_state_nxt == S_ARMED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_shadow <= '0;
         r_key    <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_key    <= w_key_nxt;
         r_ready  <= w_ready_nxt;
         r_busy   <= w_busy_nxt;
         r_err    <= w_err_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign key_out   = r_key;
   assign key_ready = r_ready;
   assign busy      = r_busy;
   assign err       = r_err;
   assign bit_cnt   = r_cnt;

endmodule

// File: tb/tb_key_loader_rll16.sv
// Self-checking bench for key_loader_rll16: directed scenarios plus random stimulus,
// compared every cycle against a queue-based model of the loading rules.
module tb_key_loader_rll16;

   localparam bit PAR_EN = 1'b1;

   logic        clk = 1'b0;
   logic        rst, load_start, ser_valid, ser_in, commit;
   logic [15:0] key_out;
   logic        key_ready, busy, err;
   logic [4:0]  bit_cnt;

   int n_checks = 0;
   int n_errors = 0;

   key_loader_rll16 #(.KEY_W(16), .PAR_EN(PAR_EN)) u_dut (
      .clk(clk), .rst(rst), .load_start(load_start), .ser_valid(ser_valid),
      .ser_in(ser_in), .commit(commit), .key_out(key_out), .key_ready(key_ready),
      .busy(busy), .err(err), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   // Model: a load is "collecting", "awaiting parity", "armed", "failed" or not active.
   bit          m_collecting, m_await_par, m_armed, m_failed;
   bit          m_bits[$];
   logic [15:0] m_key;
   bit          m_ready;

   function automatic logic [15:0] bits_value();
      logic [15:0] v = '0;
      for (int i = 0; i < m_bits.size(); i++)
         if (m_bits[i]) v = v | (16'd1 << i);
      return v;
   endfunction

   task automatic model_step(input bit r, input bit ls, input bit sv, input bit si, input bit cm);
      if (r) begin
         m_collecting = 0; m_await_par = 0; m_armed = 0; m_failed = 0;
         m_bits.delete(); m_key = '0; m_ready = 0;
      end else if (ls) begin
         m_collecting = 1; m_await_par = 0; m_armed = 0; m_failed = 0;
         m_bits.delete();
      end else if (m_collecting) begin
         if (sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == 16) begin
               m_collecting = 0;
               if (PAR_EN) m_await_par = 1; else m_armed = 1;
            end
         end
      end else if (m_await_par) begin
         if (sv) begin
            m_await_par = 0;
            if ((($countones(bits_value()) + int'(si)) % 2) == 0) m_armed = 1;
            else m_failed = 1;
         end
      end else if (m_armed && cm) begin
         m_armed = 0;
         m_key   = bits_value();
         m_ready = 1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      check("key_out", 32'(key_out), 32'(m_key));
      check("key_ready", 32'(key_ready), 32'(m_ready));
      check("busy", 32'(busy), 32'(m_collecting | m_await_par | m_armed));
      check("err", 32'(err), 32'(m_failed));
      check("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
   endtask

   task automatic cyc(input bit r, input bit ls, input bit sv, input bit si, input bit cm);
      rst = r; load_start = ls; ser_valid = sv; ser_in = si; commit = cm;
      @(posedge clk);
      model_step(r, ls, sv, si, cm);
      #1;
      check_all();
   endtask

   task automatic send_bits(input logic [15:0] k, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 1, k[i], 0);
         if (gapped) cyc(0, 0, 0, 1'($urandom), 0);
      end
   endtask

   task automatic load_key(input logic [15:0] k, input bit par, input bit gapped);
      cyc(0, 1, 1, 1, 0);
      send_bits(k, 16, gapped);
      if (PAR_EN) cyc(0, 0, 1, par, 0);
   endtask

   initial begin
      rst = 1; load_start = 0; ser_valid = 0; ser_in = 0; commit = 0;
      cyc(1, 1, 1, 1, 1);
      cyc(1, 0, 0, 0, 0);
      check("reset_key", 32'(key_out), 32'h0);

      // Nominal load
      load_key(16'hA5C3, 1'b0, 1'b0);
      check("nominal_busy_armed", 32'(busy), 32'h1);
      cyc(0, 0, 0, 0, 1);
      check("nominal_key", 32'(key_out), 32'hA5C3);
      check("nominal_ready", 32'(key_ready), 32'h1);
      check("nominal_busy_after", 32'(busy), 32'h0);

      // Parity error, then ignored commit
      load_key(16'hA5C3, 1'b1, 1'b0);
      check("parerr_err", 32'(err), 32'h1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 1, 0);
      check("parerr_key_kept", 32'(key_out), 32'hA5C3);

      // Abort
      load_key(16'h1234, 1'b1, 1'b0);
      cyc(0, 0, 0, 0, 1);
      check("abort_first_key", 32'(key_out), 32'h1234);
      cyc(0, 1, 0, 0, 0);
      send_bits(16'hFFFF, 7, 1'b0);
      check("abort_cnt7", 32'(bit_cnt), 32'd7);
      cyc(0, 1, 1, 1, 0);
      check("abort_cnt_restart", 32'(bit_cnt), 32'd0);
      send_bits(16'h00F0, 16, 1'b0);
      cyc(0, 0, 1, 1'b0, 0);
      check("abort_key_held", 32'(key_out), 32'h1234);
      cyc(0, 0, 0, 0, 1);
      check("abort_new_key", 32'(key_out), 32'h00F0);

      // Gapped stream
      load_key(16'h8001, 1'b0, 1'b1);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1);
      check("gapped_key", 32'(key_out), 32'h8001);

      // Contention in ARMED, then commit in IDLE
      load_key(16'h5A5A, 1'b0, 1'b0);
      cyc(0, 1, 0, 0, 1);
      check("contend_cnt", 32'(bit_cnt), 32'd0);
      check("contend_key", 32'(key_out), 32'h8001);
      send_bits(16'h5A5A, 16, 1'b0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      check("idle_commit_key", 32'(key_out), 32'h5A5A);

      // Reset mid-load
      cyc(0, 1, 0, 0, 0);
      send_bits(16'h3C3C, 10, 1'b0);
      cyc(1, 0, 1, 1, 1);
      check("midrst_key", 32'(key_out), 32'h0);
      check("midrst_ready", 32'(key_ready), 32'h0);
      cyc(0, 0, 1, 1, 0);
      check("midrst_cnt", 32'(bit_cnt), 32'd0);

      // Random traffic
      for (int n = 0; n < 4000; n++)
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 5) == 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/key_loader_rll16.md
KEY_LOADER_RLL16 -- requirements
Module: key_loader_rll16

Interface
REQ-001 Parameter: KEY_W, 16, key width in bits; only the value 16 is supported.
REQ-002 Parameter: PAR_EN, 1, when 1 a trailing even-parity bit is required after the key bits; when 0 the parity phase is skipped.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_start  input  1  begins a new key load; accepted in any state.
REQ-006 ser_valid  input  1  qualifies ser_in for the current cycle.
REQ-007 ser_in  input  1  serial key/parity bit, key LSB first.
REQ-008 commit  input  1  transfers the checked shadow key to key_out.
REQ-009 key_out  output  16  active key; bit i drives locked-netlist key input keyIn_0_i.
REQ-010 key_ready  output  1  key_out holds a committed key.
REQ-011 busy  output  1  high in SHIFT, PARITY or ARMED.
REQ-012 err  output  1  parity failure latched.
REQ-013 bit_cnt  output  5  key bits received in the current load, 0..16.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT, PARITY, ARMED and ERROR, held in an internal 16-bit shadow register separate from key_out.
REQ-015 load_start in any state SHALL, at the next edge: set state to SHIFT, bit_cnt to 0, shadow to 0 and err to 0; ser_valid in that same cycle is discarded.
REQ-016 In SHIFT with ser_valid=1, the block SHALL write shadow[bit_cnt] <= ser_in and increment bit_cnt by 1.
REQ-017 When the 16th bit is accepted (bit_cnt 15->16), the next state SHALL be PARITY if PAR_EN=1, otherwise ARMED.
REQ-018 In PARITY with ser_valid=1, the block SHALL go to ARMED if XOR(shadow, ser_in)=0, otherwise to ERROR with err=1.
REQ-019 In ARMED with commit=1, key_out SHALL take the shadow value at the next edge, key_ready SHALL become 1 at that edge, and the state SHALL return to IDLE (latency 1 cycle).
REQ-020 commit outside ARMED SHALL be ignored; key_out and key_ready SHALL be unchanged.
REQ-021 ser_valid in IDLE, ARMED or ERROR SHALL be ignored; bit_cnt SHALL saturate at 16.
REQ-022 key_out SHALL change only on an accepted commit; an in-progress, aborted or failed load SHALL never disturb key_out or key_ready.
REQ-023 ERROR SHALL hold err=1 until load_start or rst; commit in ERROR SHALL have no effect.
REQ-024 Simultaneous load_start and commit while in ARMED: load_start SHALL win, no transfer.
REQ-025 busy SHALL be a registered decode of the state: 1 in SHIFT, PARITY and ARMED; 0 in IDLE and ERROR.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, shadow 0, key_out 16'h0000, key_ready 0, busy 0, err 0, bit_cnt 0, overriding all other inputs.
REQ-027 rst asserted mid-load or in ARMED SHALL discard the shadow; no partial key SHALL ever reach key_out.

Verification
REQ-028 Nominal load: rst, load_start, then 16 bits of 16'hA5C3 LSB first, parity 0, commit -> key_out=16'hA5C3 and key_ready=1 one cycle after commit; busy=0 after.
REQ-029 Parity error: same key with parity 1 -> err=1, state ERROR; a following commit leaves key_out=16'hA5C3 from a previous load (or 16'h0000 after reset) and key_ready unchanged.
REQ-030 Abort: load 16'hFFFF after committing 16'h1234, assert load_start after 7 bits, then load 16'h00F0 with parity 0 and commit -> key_out=16'h1234 throughout, then 16'h00F0; bit_cnt restarts at 0.
REQ-031 Gapped stream: ser_valid toggled 1/0 every cycle while shifting 16'h8001 with parity 0 -> bit_cnt increments only on valid cycles; key_out=16'h8001 after commit.
REQ-032 Contention: in ARMED, assert load_start and commit in the same cycle -> no transfer, state SHIFT, bit_cnt=0; commit in IDLE -> no change.
REQ-033 Reset mid-load: rst after 10 bits -> all outputs at reset values next cycle; a subsequent ser_valid without load_start leaves bit_cnt=0.
